// File: rtl/utopia1_cell_tx_pkg.sv
// Shared types and constants for the Utopia level-1 ATM cell transmitter.
// Holds the 53-byte cell type, HEC constants and the transmit FSM states.
package utopia1_cell_tx_pkg;

  localparam int          CELL_BYTES = 53;
  localparam logic [7:0]  HEC_POLY   = 8'h07;
  localparam logic [7:0]  HEC_COSET  = 8'h55;
  localparam logic [5:0]  LAST_IDX   = 6'(CELL_BYTES - 1);

  // Byte 0 is cell[0]: {GFC, VPI[7:4]}; byte 4 is the HEC slot.
  typedef logic [CELL_BYTES-1:0][7:0] cell_t;
  typedef logic [3:0][7:0]            hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;

endpackage

// File: rtl/atm_hec_gen.sv
// Combinational ATM header checksum: CRC-8 (x^8+x^2+x+1) over header bytes 0..3, MSB first.
// Zero latency, no flow control; the CRC remainder is XORed with the coset value.
module atm_hec_gen
  import utopia1_cell_tx_pkg::*;
(
  input  hdr_t       hdr,
  output logic [7:0] hec
);

  logic [7:0] crc;

  always_comb begin
    crc = 8'h00;
    for (int b = 0; b < 4; b++) begin
      for (int i = 7; i >= 0; i--) begin
        if (crc[7] ^ hdr[b][i]) begin
          crc = {crc[6:0], 1'b0} ^ HEC_POLY;
        end else begin
          crc = {crc[6:0], 1'b0};
        end
      end
    end
    hec = crc ^ HEC_COSET;
  end

endmodule

// File: rtl/utopia1_cell_tx.sv
// Utopia level-1 cell transmitter: buffers one cell, streams it bytewise; byte 0 one cycle after accept.
// Receiver stalls via active-low en hold index and buffer; cell_ready only while idle.
module utopia1_cell_tx
  import utopia1_cell_tx_pkg::*;
#(
  parameter bit GEN_HEC = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  cell_t       cell_in,
  input  logic        cell_valid,
  output logic        cell_ready,
  input  logic        en,
  output logic [7:0]  data,
  output logic        soc,
  output logic        clav,
  output logic [15:0] cells_sent
);

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  cell_t       buf_q, buf_d;
  logic [15:0] cells_sent_q, cells_sent_d;
  logic [7:0]  hec;
  cell_t       cell_cap;

  atm_hec_gen u_hec (
    .hdr (cell_in[3:0]),
    .hec (hec)
  );

  always_comb begin
    cell_cap = cell_in;
    if (GEN_HEC) begin
      cell_cap[4] = hec;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      buf_q        <= '0;
      cells_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      cells_sent_q <= cells_sent_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cell_valid) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // An out-of-range index is treated as corruption and abandons the cell.
        if (idx_q > LAST_IDX) begin
          state_d = ST_IDLE;
        end else if (!en && idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    buf_d        = buf_q;
    idx_d        = idx_q;
    cells_sent_d = cells_sent_q;
    case (state_q)
      ST_IDLE: begin
        if (cell_valid) begin
          buf_d = cell_cap;
          idx_d = '0;
        end
      end
      ST_SEND: begin
        if (idx_q > LAST_IDX) begin
          idx_d = '0;
        end else if (!en) begin
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            cells_sent_d = cells_sent_q + 16'd1;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: idx_d = '0;
    endcase
  end

  always_comb begin
    cell_ready = (state_q == ST_IDLE);
    clav       = (state_q == ST_SEND) && !en;
    soc        = clav && (idx_q == '0);
    data       = 8'h00;
    if (state_q == ST_SEND && idx_q <= LAST_IDX) begin
      data = buf_q[idx_q];
    end
  end

  assign cells_sent = cells_sent_q;

endmodule
